// File: rtl/ball_collision_resolver.sv
// Resolves a ball-to-ball hit into an equal-mass elastic speed exchange with a frame-counted cooldown.
// Optional macro RESTITUTION_LOSS_EN scales every exchanged component by 7/8.
module ball_collision_resolver #(
    parameter int MAX_SPEED       = 511,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               collisionDetect,
    input  logic [3:0]         HitEdgeCode,
    input  logic               ballA_active,
    input  logic               ballB_active,
    input  logic signed [10:0] XspeedA,
    input  logic signed [10:0] YspeedA,
    input  logic signed [10:0] XspeedB,
    input  logic signed [10:0] YspeedB,
    output logic signed [10:0] XspeedA_out,
    output logic signed [10:0] YspeedA_out,
    output logic signed [10:0] XspeedB_out,
    output logic signed [10:0] YspeedB_out,
    output logic               collisionA,
    output logic               collisionB,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_COMPUTE, S_ISSUE, S_COOLDOWN
    } state_t;

    localparam logic signed [11:0] L_MAX = 12'(MAX_SPEED);
    localparam logic signed [11:0] L_MIN = -L_MAX;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [3:0]            r_code;
    logic                  r_ex_x;
    logic                  r_ex_y;
    logic signed [10:0]    r_xa, r_ya, r_xb, r_yb;
    logic signed [10:0]    r_xa_out, r_ya_out, r_xb_out, r_yb_out;
    logic                  r_coll;

    logic signed [11:0]    w_xa, w_ya, w_xb, w_yb;
    logic signed [10:0]    w_xa_new, w_ya_new, w_xb_new, w_yb_new;
    logic                  w_degen;

    function automatic logic signed [10:0] sat(input logic signed [11:0] v);
        if (v > L_MAX)      return L_MAX[10:0];
        else if (v < L_MIN) return L_MIN[10:0];
        else                return v[10:0];
    endfunction

    // Loss divides toward zero so positive and negative speeds lose the same magnitude.
    function automatic logic signed [11:0] scale(input logic signed [11:0] v);
`ifdef RESTITUTION_LOSS_EN
        logic signed [11:0] q;
        q = v[11] ? -((-v) >>> 3) : (v >>> 3);
        return v - q;
`else
        return v;
`endif
    endfunction

    always_comb begin
        w_xa = r_xa;
        w_ya = r_ya;
        w_xb = r_xb;
        w_yb = r_yb;
        w_xa_new = r_ex_x ? sat(scale(w_xb)) : sat(w_xa);
        w_xb_new = r_ex_x ? sat(scale(w_xa)) : sat(w_xb);
        w_ya_new = r_ex_y ? sat(scale(w_yb)) : sat(w_ya);
        w_yb_new = r_ex_y ? sat(scale(w_ya)) : sat(w_yb);
        w_degen  = (!r_ex_x || (r_xa == r_xb)) && (!r_ex_y || (r_ya == r_yb));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_code   <= '0;
            r_ex_x   <= 1'b0;
            r_ex_y   <= 1'b0;
            r_xa     <= '0;
            r_ya     <= '0;
            r_xb     <= '0;
            r_yb     <= '0;
            r_xa_out <= '0;
            r_ya_out <= '0;
            r_xb_out <= '0;
            r_yb_out <= '0;
            r_coll   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (collisionDetect && ballA_active && ballB_active) begin
                        r_xa    <= XspeedA;
                        r_ya    <= YspeedA;
                        r_xb    <= XspeedB;
                        r_yb    <= YspeedB;
                        r_code  <= HitEdgeCode;
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    // A corner-less code (0000) means the contact axis is unknown: exchange both.
                    r_ex_x  <= r_code[3] | r_code[1] | (r_code == 4'b0000);
                    r_ex_y  <= r_code[2] | r_code[0] | (r_code == 4'b0000);
                    r_state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (w_degen) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_xa_out <= w_xa_new;
                        r_ya_out <= w_ya_new;
                        r_xb_out <= w_xb_new;
                        r_yb_out <= w_yb_new;
                        r_coll   <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_coll  <= 1'b0;
                    r_cnt   <= 4'(COOLDOWN_FRAMES);
                    r_state <= S_COOLDOWN;
                end
                S_COOLDOWN: begin
                    if (startOfFrame) begin
                        if (r_cnt <= 4'd1) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign XspeedA_out = r_xa_out;
    assign YspeedA_out = r_ya_out;
    assign XspeedB_out = r_xb_out;
    assign YspeedB_out = r_yb_out;
    assign collisionA  = r_coll;
    assign collisionB  = r_coll;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ball_collision_resolver.sv
// Bench for ball_collision_resolver: vector table, corner sequences and a randomized model comparison.
module tb_ball_collision_resolver;

    localparam int MAXS = 511;
    localparam int CD   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               resetN, startOfFrame, collisionDetect;
    logic [3:0]         HitEdgeCode;
    logic               ballA_active, ballB_active;
    logic signed [10:0] XspeedA, YspeedA, XspeedB, YspeedB;
    logic signed [10:0] XspeedA_out, YspeedA_out, XspeedB_out, YspeedB_out;
    logic               collisionA, collisionB, busy;

    ball_collision_resolver #(.MAX_SPEED(MAXS), .COOLDOWN_FRAMES(CD)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .collisionDetect(collisionDetect), .HitEdgeCode(HitEdgeCode),
        .ballA_active(ballA_active), .ballB_active(ballB_active),
        .XspeedA(XspeedA), .YspeedA(YspeedA), .XspeedB(XspeedB), .YspeedB(YspeedB),
        .XspeedA_out(XspeedA_out), .YspeedA_out(YspeedA_out),
        .XspeedB_out(XspeedB_out), .YspeedB_out(YspeedB_out),
        .collisionA(collisionA), .collisionB(collisionB), .busy(busy)
    );

    typedef struct {
        int xa, ya, xb, yb;
        logic [3:0] code;
        int exa, eya, exb, eyb;
        int npulse;
    } vec_t;

    vec_t tbl[6];
    int checks = 0;
    int failures = 0;
    int m_xa = 0, m_ya = 0, m_xb = 0, m_yb = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic int clampv(input int v);
        if (v > MAXS) return MAXS;
        if (v < -MAXS) return -MAXS;
        return v;
    endfunction

    function automatic int lossv(input int v);
`ifdef RESTITUTION_LOSS_EN
        return v - v / 8;
`else
        return v;
`endif
    endfunction

    // Reference: exchange the speed pair along the contact axes, equal-mass elastic hit.
    task automatic model(input int xa, ya, xb, yb, input logic [3:0] code,
                         output int oxa, oya, oxb, oyb, output int np);
        bit ex, ey;
        ex = (code[3] || code[1] || code == 0);
        ey = (code[2] || code[0] || code == 0);
        if ((!ex || xa == xb) && (!ey || ya == yb)) begin
            oxa = m_xa; oya = m_ya; oxb = m_xb; oyb = m_yb; np = 0;
        end else begin
            oxa = ex ? clampv(lossv(xb)) : clampv(xa);
            oxb = ex ? clampv(lossv(xa)) : clampv(xb);
            oya = ey ? clampv(lossv(yb)) : clampv(ya);
            oyb = ey ? clampv(lossv(ya)) : clampv(yb);
            np = 1;
        end
    endtask

    task automatic arm_and_observe(input int xa, ya, xb, yb, input logic [3:0] code,
                                   output int npa, output int npb, output int first_k);
        @(negedge clk);
        XspeedA = 11'(xa); YspeedA = 11'(ya); XspeedB = 11'(xb); YspeedB = 11'(yb);
        HitEdgeCode = code; ballA_active = 1'b1; ballB_active = 1'b1;
        collisionDetect = 1'b1;
        @(posedge clk);
        @(negedge clk);
        collisionDetect = 1'b0;
        npa = 0; npb = 0; first_k = -1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (collisionA) begin npa++; if (first_k < 0) first_k = k; end
            if (collisionB) npb++;
        end
    endtask

    task automatic drain(input string name, input int exp_sof);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk); startOfFrame = 1'b1;
            @(negedge clk); startOfFrame = 1'b0;
            n++;
        end
        chk(name, n, exp_sof);
    endtask

    task automatic check_outs(input string name, input int exa, eya, exb, eyb);
        chk({name, "_xa"}, XspeedA_out, exa);
        chk({name, "_ya"}, YspeedA_out, eya);
        chk({name, "_xb"}, XspeedB_out, exb);
        chk({name, "_yb"}, YspeedB_out, eyb);
    endtask

    task automatic run_case(input string name, input int xa, ya, xb, yb, input logic [3:0] code,
                            input int exa, eya, exb, eyb, input int np);
        int npa, npb, fk;
        arm_and_observe(xa, ya, xb, yb, code, npa, npb, fk);
        chk({name, "_pulseA"}, npa, np);
        chk({name, "_pulseB"}, npb, np);
        if (np == 1) chk({name, "_latency"}, fk, 2);
        check_outs(name, exa, eya, exb, eyb);
        drain({name, "_sof"}, (np == 1) ? CD : 0);
        m_xa = exa; m_ya = eya; m_xb = exb; m_yb = eyb;
    endtask

    task automatic run_model(input string name, input int xa, ya, xb, yb, input logic [3:0] code);
        int exa, eya, exb, eyb, np;
        model(xa, ya, xb, yb, code, exa, eya, exb, eyb, np);
        run_case(name, xa, ya, xb, yb, code, exa, eya, exb, eyb, np);
    endtask

    initial begin
        int npa, npb, fk;
        resetN = 1'b0; startOfFrame = 1'b0; collisionDetect = 1'b0; HitEdgeCode = '0;
        ballA_active = 1'b1; ballB_active = 1'b1;
        XspeedA = '0; YspeedA = '0; XspeedB = '0; YspeedB = '0;

        tbl[0] = '{40, 0, 0, 0, 4'b1000, 0, 0, 40, 0, 1};
`ifdef RESTITUTION_LOSS_EN
        tbl[0] = '{40, 0, 0, 0, 4'b1000, 0, 0, 35, 0, 1};
        tbl[1] = '{10, -30, 5, 20, 4'b0100, 10, 18, 5, -27, 1};
        tbl[2] = '{600, 0, -511, 3, 4'b0000, -448, 3, 511, 0, 1};
        tbl[3] = '{7, 7, 7, 7, 4'b0000, -448, 3, 511, 0, 0};
        tbl[4] = '{-100, 50, 200, -7, 4'b0010, 175, 50, -88, -7, 1};
`else
        tbl[1] = '{10, -30, 5, 20, 4'b0100, 10, 20, 5, -30, 1};
        tbl[2] = '{600, 0, -511, 3, 4'b0000, -511, 3, 511, 0, 1};
        tbl[3] = '{7, 7, 7, 7, 4'b0000, -511, 3, 511, 0, 0};
        tbl[4] = '{-100, 50, 200, -7, 4'b0010, 200, 50, -100, -7, 1};
`endif
        tbl[5] = '{1, -1000, 2, 900, 4'b0001, 1, 511, 2, -511, 1};

        repeat (3) @(negedge clk);
        check_outs("reset", 0, 0, 0, 0);
        chk("reset_busy", busy, 0);
        chk("reset_collA", collisionA, 0);
        chk("reset_collB", collisionB, 0);
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_case($sformatf("vec%0d", i), tbl[i].xa, tbl[i].ya, tbl[i].xb, tbl[i].yb,
                     tbl[i].code, tbl[i].exa, tbl[i].eya, tbl[i].exb, tbl[i].eyb, tbl[i].npulse);

        // Detect held high across the whole cooldown: one pulse pair, re-arm only after the 4th frame.
        begin
            int na;
            na = 0;
            @(negedge clk);
            XspeedA = 11'(3); YspeedA = 11'(4); XspeedB = 11'(5); YspeedB = 11'(6);
            HitEdgeCode = 4'b1000; collisionDetect = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (collisionA) na++;
            end
            for (int f = 1; f <= CD; f++) begin
                startOfFrame = 1'b1;
                @(negedge clk);
                startOfFrame = 1'b0;
                if (collisionA) na++;
                if (f == CD - 1) chk("hold_busy_f3", busy, 1);
                if (f == CD) chk("hold_busy_f4", busy, 0);
                if (f < CD) begin
                    @(negedge clk);
                    if (collisionA) na++;
                end
            end
            chk("hold_pulses", na, 1);
            @(negedge clk);
            chk("hold_rearm", busy, 1);
            collisionDetect = 1'b0;
            repeat (5) @(negedge clk);
            drain("hold_sof", CD);
            m_xa = 5; m_ya = 4; m_xb = 3; m_yb = 6;
            check_outs("hold", 5, 4, 3, 6);
        end

        // Inactive ball B never arms the resolver.
        begin
            int na;
            na = 0;
            @(negedge clk);
            ballB_active = 1'b0; collisionDetect = 1'b1;
            XspeedA = 11'(50); XspeedB = 11'(-50); HitEdgeCode = 4'b1000;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (collisionA || collisionB || busy) na++;
            end
            chk("inactiveB_idle", na, 0);
            collisionDetect = 1'b0; ballB_active = 1'b1;
        end

        // Reset during COOLDOWN.
        arm_and_observe(100, 0, -50, 0, 4'b1000, npa, npb, fk);
        chk("rstcd_pulse", npa, 1);
        chk("rstcd_busy_pre", busy, 1);
        resetN = 1'b0;
        #1;
        chk("rstcd_busy", busy, 0);
        check_outs("rstcd", 0, 0, 0, 0);
        @(negedge clk); resetN = 1'b1;
        npa = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (collisionA || collisionB || busy) npa++;
        end
        chk("rstcd_quiet", npa, 0);
        m_xa = 0; m_ya = 0; m_xb = 0; m_yb = 0;
        run_model("rstcd_rearm", 30, -20, -10, 40, 4'b1010);

        // Reset during LATCH.
        @(negedge clk);
        XspeedA = 11'(60); YspeedA = 11'(0); XspeedB = 11'(-60); YspeedB = 11'(0);
        HitEdgeCode = 4'b1000; collisionDetect = 1'b1;
        @(posedge clk);
        #1;
        resetN = 1'b0; collisionDetect = 1'b0;
        #1;
        chk("rstlt_busy", busy, 0);
        check_outs("rstlt", 0, 0, 0, 0);
        @(negedge clk); resetN = 1'b1;
        npa = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (collisionA || collisionB || busy) npa++;
        end
        chk("rstlt_quiet", npa, 0);
        m_xa = 0; m_ya = 0; m_xb = 0; m_yb = 0;
        run_model("rstlt_rearm", 60, 0, -60, 0, 4'b1000);

        for (int i = 0; i < 30; i++) begin
            int xa, ya, xb, yb;
            logic [3:0] code;
            xa = int'($urandom_range(0, 2047)) - 1024;
            ya = int'($urandom_range(0, 2047)) - 1024;
            xb = int'($urandom_range(0, 2047)) - 1024;
            yb = int'($urandom_range(0, 2047)) - 1024;
            code = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin xb = xa; yb = ya; end
            run_model($sformatf("rnd%0d", i), xa, ya, xb, yb, code);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
